// File: rtl/main_mem_ctrl.sv
// Block-organised main memory serving icache reads and dcache reads/writes, one request at a time.
// Optional round-robin arbitration when MAIN_MEM_CTRL_RR_ARB_EN is defined (fixed dcache priority otherwise).
module main_mem_ctrl #(
  parameter int unsigned N_BLOCKS        = 1024,
  parameter int unsigned BLOCK_BITS      = 512,
  parameter int unsigned BLOCK_ADDR_BITS = 10,
  parameter int unsigned LATENCY         = 4
) (
  input  logic                       clk,
  input  logic                       rst_aL,
  input  logic                       init_wr_en,
  input  logic [BLOCK_ADDR_BITS-1:0] init_wr_block_addr,
  input  logic [BLOCK_BITS-1:0]      init_wr_block_data,
  input  logic                       icache_req_valid,
  input  logic [BLOCK_ADDR_BITS-1:0] icache_req_block_addr,
  output logic                       icache_req_ready,
  output logic                       icache_resp_valid,
  output logic [BLOCK_BITS-1:0]      icache_resp_block_data,
  input  logic                       dcache_req_valid,
  input  logic                       dcache_req_type,
  input  logic [BLOCK_ADDR_BITS-1:0] dcache_req_block_addr,
  input  logic [BLOCK_BITS-1:0]      dcache_req_block_data,
  output logic                       dcache_req_ready,
  output logic                       dcache_resp_valid,
  output logic [BLOCK_BITS-1:0]      dcache_resp_block_data,
  output logic                       busy
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
  typedef enum logic {CLIENT_ICACHE = 1'b0, CLIENT_DCACHE = 1'b1} client_t;
  typedef enum logic {REQ_READ = 1'b0, REQ_WRITE = 1'b1} req_type_t;

  typedef struct packed {
    client_t                    client;
    req_type_t                  req_type;
    logic [BLOCK_ADDR_BITS-1:0] addr;
    logic [BLOCK_BITS-1:0]      data;
  } req_t;

  logic [BLOCK_BITS-1:0] mem [N_BLOCKS];

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  req_t                       req_q, req_d;
  logic                       mem_we;
  logic [BLOCK_ADDR_BITS-1:0] mem_waddr;
  logic [BLOCK_BITS-1:0]      mem_wdata;
  logic [BLOCK_BITS-1:0]      resp_data_c;
  logic                       idle_open_c;
  logic                       icache_acc_c, dcache_acc_c;

  // Requests are only taken in IDLE, out of reset, and when no preload is pending.
  assign idle_open_c = rst_aL && (state_q == IDLE) && !init_wr_en;

`ifdef MAIN_MEM_CTRL_RR_ARB_EN
  client_t last_grant_q;

  assign icache_req_ready = idle_open_c && (!dcache_req_valid || (last_grant_q == CLIENT_DCACHE));
  assign dcache_req_ready = idle_open_c && (!icache_req_valid || (last_grant_q == CLIENT_ICACHE));

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      last_grant_q <= CLIENT_ICACHE;
    end else if (dcache_acc_c) begin
      last_grant_q <= CLIENT_DCACHE;
    end else if (icache_acc_c) begin
      last_grant_q <= CLIENT_ICACHE;
    end
  end
`else
  assign dcache_req_ready = idle_open_c;
  assign icache_req_ready = idle_open_c && !dcache_req_valid;
`endif

  assign dcache_acc_c = dcache_req_valid && dcache_req_ready;
  assign icache_acc_c = icache_req_valid && icache_req_ready;

  // Next-state, request latch and array write control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    mem_we    = 1'b0;
    mem_waddr = init_wr_block_addr;
    mem_wdata = init_wr_block_data;
    unique case (state_q)
      IDLE: begin
        if (init_wr_en) begin
          mem_we = 1'b1;
        end else if (dcache_acc_c || icache_acc_c) begin
          req_d.client   = dcache_acc_c ? CLIENT_DCACHE : CLIENT_ICACHE;
          req_d.req_type = (dcache_acc_c && dcache_req_type) ? REQ_WRITE : REQ_READ;
          req_d.addr     = dcache_acc_c ? dcache_req_block_addr : icache_req_block_addr;
          req_d.data     = dcache_req_block_data;
          if (req_d.req_type == REQ_WRITE) begin
            mem_we    = 1'b1;
            mem_waddr = req_d.addr;
            mem_wdata = req_d.data;
          end
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Writes echo their own data so a LATENCY=1 write sees the new value, not the pre-write array.
  assign resp_data_c = (req_d.req_type == REQ_WRITE) ? req_d.data : mem[req_d.addr];

  always_ff @(posedge clk) begin
    if (mem_we && rst_aL) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      state_q                <= IDLE;
      cnt_q                  <= '0;
      req_q                  <= '0;
      busy                   <= 1'b0;
      icache_resp_valid      <= 1'b0;
      dcache_resp_valid      <= 1'b0;
      icache_resp_block_data <= '0;
      dcache_resp_block_data <= '0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      req_q             <= req_d;
      busy              <= (state_d != IDLE);
      icache_resp_valid <= (state_d == RESP) && (req_d.client == CLIENT_ICACHE);
      dcache_resp_valid <= (state_d == RESP) && (req_d.client == CLIENT_DCACHE);
      if (state_d == RESP) begin
        if (req_d.client == CLIENT_DCACHE) begin
          dcache_resp_block_data <= resp_data_c;
        end else begin
          icache_resp_block_data <= resp_data_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Self-checking bench for main_mem_ctrl: reference model of memory contents, arbitration and response timing.
module tb_main_mem_ctrl;

  localparam int unsigned NB  = 1024;
  localparam int unsigned BB  = 512;
  localparam int unsigned AB  = 10;
  localparam int unsigned LAT = 4;
  localparam int unsigned SN  = 16;
  localparam int unsigned SB  = 32;
  localparam int unsigned SA  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_aL;
  logic          init_wr_en;
  logic [AB-1:0] init_wr_block_addr;
  logic [BB-1:0] init_wr_block_data;
  logic          icache_req_valid;
  logic [AB-1:0] icache_req_block_addr;
  logic          icache_req_ready;
  logic          icache_resp_valid;
  logic [BB-1:0] icache_resp_block_data;
  logic          dcache_req_valid;
  logic          dcache_req_type;
  logic [AB-1:0] dcache_req_block_addr;
  logic [BB-1:0] dcache_req_block_data;
  logic          dcache_req_ready;
  logic          dcache_resp_valid;
  logic [BB-1:0] dcache_resp_block_data;
  logic          busy;

  logic          s_init_wr_en;
  logic [SA-1:0] s_init_wr_block_addr;
  logic [SB-1:0] s_init_wr_block_data;
  logic          s_icache_req_valid;
  logic [SA-1:0] s_icache_req_block_addr;
  logic          s_icache_req_ready;
  logic          s_icache_resp_valid;
  logic [SB-1:0] s_icache_resp_block_data;
  logic          s_dcache_req_valid;
  logic          s_dcache_req_type;
  logic [SA-1:0] s_dcache_req_block_addr;
  logic [SB-1:0] s_dcache_req_block_data;
  logic          s_dcache_req_ready;
  logic          s_dcache_resp_valid;
  logic [SB-1:0] s_dcache_resp_block_data;
  logic          s_busy;

  main_mem_ctrl #(.N_BLOCKS(NB), .BLOCK_BITS(BB), .BLOCK_ADDR_BITS(AB), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst_aL(rst_aL),
    .init_wr_en(init_wr_en), .init_wr_block_addr(init_wr_block_addr), .init_wr_block_data(init_wr_block_data),
    .icache_req_valid(icache_req_valid), .icache_req_block_addr(icache_req_block_addr),
    .icache_req_ready(icache_req_ready), .icache_resp_valid(icache_resp_valid),
    .icache_resp_block_data(icache_resp_block_data),
    .dcache_req_valid(dcache_req_valid), .dcache_req_type(dcache_req_type),
    .dcache_req_block_addr(dcache_req_block_addr), .dcache_req_block_data(dcache_req_block_data),
    .dcache_req_ready(dcache_req_ready), .dcache_resp_valid(dcache_resp_valid),
    .dcache_resp_block_data(dcache_resp_block_data), .busy(busy)
  );

  main_mem_ctrl #(.N_BLOCKS(SN), .BLOCK_BITS(SB), .BLOCK_ADDR_BITS(SA), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst_aL(rst_aL),
    .init_wr_en(s_init_wr_en), .init_wr_block_addr(s_init_wr_block_addr), .init_wr_block_data(s_init_wr_block_data),
    .icache_req_valid(s_icache_req_valid), .icache_req_block_addr(s_icache_req_block_addr),
    .icache_req_ready(s_icache_req_ready), .icache_resp_valid(s_icache_resp_valid),
    .icache_resp_block_data(s_icache_resp_block_data),
    .dcache_req_valid(s_dcache_req_valid), .dcache_req_type(s_dcache_req_type),
    .dcache_req_block_addr(s_dcache_req_block_addr), .dcache_req_block_data(s_dcache_req_block_data),
    .dcache_req_ready(s_dcache_req_ready), .dcache_resp_valid(s_dcache_resp_valid),
    .dcache_resp_block_data(s_dcache_resp_block_data), .busy(s_busy)
  );

  // Reference model: memory image, period of the pending response, and who/what it returns.
  logic [BB-1:0] ref_mem [NB];
  int            p;
  int            resp_p;
  logic          resp_cli;
  logic [BB-1:0] resp_dat;
  logic          last_d;
  logic          acc_i, acc_d;
  int            n_assert;
  int            n_fail;

  task automatic chk(input string tag, input logic [BB-1:0] obs, input logic [BB-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BB-1:0] rnd_block();
    logic [BB-1:0] r;
    for (int i = 0; i < int'(BB / 32); i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock period: check outputs mid-cycle against the model, then advance the model across the edge.
  task automatic step();
    logic free, er_i, er_d, ev_i, ev_d, ad, ai;
    @(negedge clk);
    if (!rst_aL) begin
      resp_p = -100;
      last_d = 1'b0;
    end
    free = rst_aL && (p > resp_p);
`ifdef MAIN_MEM_CTRL_RR_ARB_EN
    er_i = free && !init_wr_en && (!dcache_req_valid || last_d);
    er_d = free && !init_wr_en && (!icache_req_valid || !last_d);
`else
    er_i = free && !init_wr_en && !dcache_req_valid;
    er_d = free && !init_wr_en;
`endif
    ev_i = rst_aL && (p == resp_p) && !resp_cli;
    ev_d = rst_aL && (p == resp_p) && resp_cli;
    chk("icache_req_ready", BB'(icache_req_ready), BB'(er_i));
    chk("dcache_req_ready", BB'(dcache_req_ready), BB'(er_d));
    chk("busy", BB'(busy), BB'(rst_aL && (p <= resp_p)));
    chk("icache_resp_valid", BB'(icache_resp_valid), BB'(ev_i));
    chk("dcache_resp_valid", BB'(dcache_resp_valid), BB'(ev_d));
    if (ev_i) chk("icache_resp_data", icache_resp_block_data, resp_dat);
    if (ev_d) chk("dcache_resp_data", dcache_resp_block_data, resp_dat);
    if (!rst_aL) begin
      chk("icache_data_rst", icache_resp_block_data, '0);
      chk("dcache_data_rst", dcache_resp_block_data, '0);
    end
    ad = er_d && dcache_req_valid;
    ai = er_i && icache_req_valid && !ad;
    acc_d = ad;
    acc_i = ai;
    if (ad) begin
      resp_p   = p + int'(LAT);
      resp_cli = 1'b1;
      last_d   = 1'b1;
      if (dcache_req_type) begin
        ref_mem[dcache_req_block_addr] = dcache_req_block_data;
        resp_dat = dcache_req_block_data;
      end else begin
        resp_dat = ref_mem[dcache_req_block_addr];
      end
    end else if (ai) begin
      resp_p   = p + int'(LAT);
      resp_cli = 1'b0;
      last_d   = 1'b0;
      resp_dat = ref_mem[icache_req_block_addr];
    end else if (free && init_wr_en) begin
      ref_mem[init_wr_block_addr] = init_wr_block_data;
    end
    @(posedge clk);
    #1;
    p++;
  endtask

  task automatic wait_acc(input logic want_d);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      step();
      got = want_d ? acc_d : acc_i;
    end
    chk(want_d ? "dcache_accept_timeout" : "icache_accept_timeout", BB'(got), BB'(1'b1));
  endtask

  task automatic drain();
    repeat (LAT + 2) step();
  endtask

  // Hold both requests until each has been accepted once; the model checks who wins when.
  task automatic conflict(input logic [AB-1:0] ia, input logic [AB-1:0] da);
    logic di, dd;
    di = 1'b0;
    dd = 1'b0;
    icache_req_valid = 1'b1; icache_req_block_addr = ia;
    dcache_req_valid = 1'b1; dcache_req_type = 1'b0; dcache_req_block_addr = da;
    for (int k = 0; k < 40 && !(di && dd); k++) begin
      step();
      if (acc_i) begin di = 1'b1; icache_req_valid = 1'b0; end
      if (acc_d) begin dd = 1'b1; dcache_req_valid = 1'b0; end
    end
    chk("conflict_timeout", BB'({di, dd}), BB'(2'b11));
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BB-1:0] wd;
    n_assert = 0; n_fail = 0; p = 0; resp_p = -100; resp_cli = 1'b0; resp_dat = '0; last_d = 1'b0;
    acc_i = 1'b0; acc_d = 1'b0;
    rst_aL = 1'b0;
    init_wr_en = 1'b0; init_wr_block_addr = '0; init_wr_block_data = '0;
    icache_req_valid = 1'b0; icache_req_block_addr = '0;
    dcache_req_valid = 1'b0; dcache_req_type = 1'b0; dcache_req_block_addr = '0; dcache_req_block_data = '0;
    s_init_wr_en = 1'b0; s_init_wr_block_addr = '0; s_init_wr_block_data = '0;
    s_icache_req_valid = 1'b0; s_icache_req_block_addr = '0;
    s_dcache_req_valid = 1'b0; s_dcache_req_type = 1'b0; s_dcache_req_block_addr = '0; s_dcache_req_block_data = '0;

    // Reset state, with requests pending to show readys stay low in reset.
    dcache_req_valid = 1'b1;
    icache_req_valid = 1'b1;
    repeat (2) step();
    dcache_req_valid = 1'b0;
    icache_req_valid = 1'b0;
    rst_aL = 1'b1;

    // Preload every block; block 5 gets the A5 pattern; icache read of 5 waits behind the final preload.
    for (int a = 0; a < int'(NB); a++) begin
      init_wr_en = 1'b1;
      init_wr_block_addr = AB'(a);
      init_wr_block_data = (a == 5) ? {64{8'hA5}} : rnd_block();
      icache_req_valid = (a == int'(NB) - 1);
      icache_req_block_addr = AB'(5);
      step();
    end
    init_wr_en = 1'b0;
    wait_acc(1'b0);
    icache_req_valid = 1'b0;
    drain();

    // Write then read back block 7.
    dcache_req_valid = 1'b1; dcache_req_type = 1'b1; dcache_req_block_addr = AB'(7);
    dcache_req_block_data = BB'(16'h1234);
    wait_acc(1'b1);
    dcache_req_valid = 1'b0;
    drain();
    dcache_req_valid = 1'b1; dcache_req_type = 1'b0; dcache_req_block_data = rnd_block();
    wait_acc(1'b1);
    dcache_req_valid = 1'b0;
    drain();

    // Two repeated conflicts.
    conflict(AB'(1), AB'(2));
    conflict(AB'(3), AB'(4));

    // Random traffic including preloads, writes, conflicts and address extremes.
    for (int k = 0; k < 400; k++) begin
      init_wr_en = ($urandom_range(0, 7) == 0);
      init_wr_block_addr = AB'($urandom);
      init_wr_block_data = rnd_block();
      icache_req_valid = 1'($urandom_range(0, 1));
      icache_req_block_addr = (k % 50 == 0) ? AB'(NB - 1) : AB'($urandom);
      dcache_req_valid = 1'($urandom_range(0, 1));
      dcache_req_type = 1'($urandom_range(0, 1));
      dcache_req_block_addr = (k % 40 == 0) ? AB'(0) : AB'($urandom);
      dcache_req_block_data = rnd_block();
      step();
    end
    init_wr_en = 1'b0; icache_req_valid = 1'b0; dcache_req_valid = 1'b0;
    drain();

    // Reset two cycles after accepting a write: no response, but the write stays in the array.
    wd = rnd_block();
    dcache_req_valid = 1'b1; dcache_req_type = 1'b1; dcache_req_block_addr = AB'(9); dcache_req_block_data = wd;
    wait_acc(1'b1);
    dcache_req_valid = 1'b0;
    repeat (2) step();
    rst_aL = 1'b0;
    step();
    rst_aL = 1'b1;
    drain();
    dcache_req_valid = 1'b1; dcache_req_type = 1'b0; dcache_req_block_addr = AB'(9);
    wait_acc(1'b1);
    dcache_req_valid = 1'b0;
    drain();
    chk("write_kept_across_reset", ref_mem[9], wd);

    // LATENCY=1 instance: preload blocks readys, then one request every two cycles.
    s_init_wr_en = 1'b1; s_init_wr_block_addr = SA'(3); s_init_wr_block_data = 32'hCAFE0003;
    s_dcache_req_valid = 1'b1; s_dcache_req_block_addr = SA'(3);
    @(negedge clk);
    chk("lat1_ready_preload", BB'(s_dcache_req_ready), BB'(1'b0));
    @(posedge clk); #1;
    s_init_wr_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("lat1_ready", BB'(s_dcache_req_ready), BB'(k % 2 == 0));
      chk("lat1_resp_valid", BB'(s_dcache_resp_valid), BB'(k % 2 == 1));
      chk("lat1_busy", BB'(s_busy), BB'(k % 2 == 1));
      if (k % 2 == 1) chk("lat1_resp_data", BB'(s_dcache_resp_block_data), BB'(32'hCAFE0003));
      @(posedge clk); #1;
    end
    s_dcache_req_type = 1'b1; s_dcache_req_block_addr = SA'(4); s_dcache_req_block_data = 32'h5A5A5A5A;
    @(negedge clk);
    chk("lat1_wr_ready", BB'(s_dcache_req_ready), BB'(1'b1));
    @(posedge clk); #1;
    s_dcache_req_valid = 1'b0; s_dcache_req_type = 1'b0;
    @(negedge clk);
    chk("lat1_wr_resp_valid", BB'(s_dcache_resp_valid), BB'(1'b1));
    chk("lat1_wr_echo", BB'(s_dcache_resp_block_data), BB'(32'h5A5A5A5A));
    @(posedge clk); #1;
    s_dcache_req_valid = 1'b1; s_dcache_req_block_data = 32'h0;
    @(negedge clk);
    chk("lat1_rd_ready", BB'(s_dcache_req_ready), BB'(1'b1));
    @(posedge clk); #1;
    s_dcache_req_valid = 1'b0;
    @(negedge clk);
    chk("lat1_rd_resp_valid", BB'(s_dcache_resp_valid), BB'(1'b1));
    chk("lat1_rd_data", BB'(s_dcache_resp_block_data), BB'(32'h5A5A5A5A));
    chk("lat1_icache_quiet", BB'(s_icache_resp_valid), BB'(1'b0));
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
